ysyx_idu_issue_q: RTL and testbench
===================================

// Module: ysyx_idu_issue_q
// PURPOSE
//  Parametrised decode/issue front end: buffers fetched instructions in a DEPTH-entry FIFO and checks
//  the head against the register scoreboard. It captures rs1/rs2 operands from the regfile or from
//  NFWD forwarding channels, then issues into a registered output stage feeding the decoder/EXU.
//  Adds in-order buffering, flush, precise rs2 use and multi-port forwarding.
// PARAMETERS
//  XLEN    32  data/PC width
//  RIDX_W  4   register index width (4 = RV32E, 5 = RV32I); NREG = 1<<RIDX_W
//  DEPTH   4   FIFO entries; power of two, >= 2
//  NFWD    2   forwarding channels; channel 0 has highest priority
// PORTS
//  clk        in   1              clock
//  rst        in   1              reset, synchronous, active-high
//  flush      in   1              squash all buffered and issued-not-accepted instructions
//  in_valid   in   1              fetch offers instruction
//  in_ready   out  1              FIFO can accept (= count != DEPTH)
//  in_inst    in   32             instruction word
//  in_pc      in   XLEN           instruction PC
//  in_spec    in   1              speculative-fetch tag
//  rs1_o      out  RIDX_W         regfile read index 1 (= head inst[15+:RIDX_W])
//  rs2_o      out  RIDX_W         regfile read index 2 (= head inst[20+:RIDX_W])
//  rdata1     in   XLEN           regfile data for rs1_o, same cycle
//  rdata2     in   XLEN           regfile data for rs2_o, same cycle
//  rf_busy    in   NREG           scoreboard: bit r = register r has a pending write
//  fwd_valid  in   NFWD           forwarding channel valid
//  fwd_rd     in   NFWD*RIDX_W    forwarding destination, channel k at [k*RIDX_W+:RIDX_W]
//  fwd_data   in   NFWD*XLEN      forwarding value, channel k at [k*XLEN+:XLEN]
//  out_valid  out  1              issued instruction valid
//  out_ready  in   1              downstream accepts
//  out_inst   out  32             issued instruction
//  out_pc     out  XLEN           issued PC
//  out_rs1v   out  XLEN           captured rs1 operand
//  out_rs2v   out  XLEN           captured rs2 operand
//  out_spec   out  1              issued speculative tag
//  stall_cnt  out  32             cycles head was valid but blocked by hazard (saturating)
// BEHAVIOUR
//  Reset: FIFO pointers/count 0, out_valid 0, all out_* data 0, stall_cnt 0; in_ready 1 on first cycle after.
//  Push: in_valid & in_ready & !flush writes tail on the edge. Pointers wrap modulo DEPTH.
//  Full: in_ready=0, so no push that cycle even if a pop occurs.
//  Use: uses_rs1 = opcode not in {LUI,AUIPC,JAL}; uses_rs2 = opcode in {BRANCH,STORE,OP}.
//  Hit: match_k = fwd_valid[k] & fwd_rd_k==idx & idx!=0.
//  Hazard per operand: used & idx!=0 & rf_busy[idx] & no match_k on any k.
//  Operand value: lowest-index matching channel's fwd_data, else rdata; x0 always yields 0.
//  Issue: head valid & !hazard & (!out_valid | out_ready) & !flush. On the edge: pop head;
//   load out_* with captured operands; out_valid<=1.
//  Accept without issue: out_valid & out_ready & no issue -> out_valid<=0.
//  Hold: out_* stay stable while out_valid & !out_ready.
//  Latency: push at edge t -> head visible after t -> earliest out_valid after edge t+1 (2 cycles);
//   sustained throughput 1/cycle.
//  Flush: count, pointers, out_valid cleared at that edge. Same-cycle push and issue are dropped.
//   Flush has priority over every other event.
//  stall_cnt: +1 each cycle head valid & hazard & !flush; saturates at 32'hFFFF_FFFF.
//  Reset mid-operation: identical to flush plus stall_cnt cleared.
//  Simultaneous push+pop when not full: count unchanged, both pointers advance.
// TESTING
//  Fill: push 4 ADDI (pc 0x0,4,8,C) with out_ready=0 -> in_ready=0 after 4th; out_pc=0x0 held; 5th push refused.
//  Hazard: rf_busy[5]=1, head ADD x1,x5,x6, no fwd -> out_valid stays 0, stall_cnt counts 3 over 3 cycles;
//   clearing rf_busy[5] -> issues the next edge.
//  Forward priority: fwd0 rd=5 data=0x11, fwd1 rd=5 data=0x22, head rs1=x5 -> out_rs1v=0x11.
//  x0/use: head LUI or JAL with rf_busy all-ones -> issues. ADDI x1,x0,1 -> out_rs1v=0, no hazard on rs2 field.
//  Flush: 3 buffered + out_valid=1, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
//  Wrap: stream 10 instructions, out_ready=1 -> out_pc in order 0x0..0x24, one per cycle after 2-cycle fill.

Source files
------------

// File: rtl/ysyx_idu_issue_q.sv
// Decode/issue front end: DEPTH-entry instruction FIFO, scoreboard hazard check on the head,
// rs1/rs2 operand capture from regfile or forwarding channels, and a registered issue stage.
module ysyx_idu_issue_q #(
  parameter  int XLEN   = 32,
  parameter  int RIDX_W = 4,
  parameter  int DEPTH  = 4,
  parameter  int NFWD   = 2,
  localparam int NREG   = 1 << RIDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     in_spec,
  output logic [RIDX_W-1:0]        rs1_o,
  output logic [RIDX_W-1:0]        rs2_o,
  input  logic [XLEN-1:0]          rdata1,
  input  logic [XLEN-1:0]          rdata2,
  input  logic [NREG-1:0]          rf_busy,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [NFWD*RIDX_W-1:0]   fwd_rd,
  input  logic [NFWD*XLEN-1:0]     fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_rs1v,
  output logic [XLEN-1:0]          out_rs2v,
  output logic                     out_spec,
  output logic [31:0]              stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0]      inst_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic             spec_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             out_valid_q;
  logic [31:0]      out_inst_q;
  logic [XLEN-1:0]  out_pc_q, out_rs1v_q, out_rs2v_q;
  logic             out_spec_q;
  logic [31:0]      stall_cnt_q;

  logic             head_valid, push, pop, issue, hazard;
  logic [31:0]      head_inst;
  logic [6:0]       opcode;
  logic             uses_rs1, uses_rs2;
  logic             hit1, hit2, haz1, haz2;
  logic [XLEN-1:0]  val1, val2;

  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign head_inst  = inst_mem[rd_ptr_q];
  assign opcode     = head_inst[6:0];
  assign rs1_o      = head_inst[15 +: RIDX_W];
  assign rs2_o      = head_inst[20 +: RIDX_W];

  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 =  (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP);

  // Returns {hit, value}; scanning from the top index down lets channel 0 win ties.
  function automatic logic [XLEN:0] resolve(input logic [RIDX_W-1:0] idx,
                                            input logic [XLEN-1:0]   rdata);
    logic            hit;
    logic [XLEN-1:0] val;
    hit = 1'b0;
    val = rdata;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && fwd_rd[k*RIDX_W +: RIDX_W] == idx) begin
        hit = 1'b1;
        val = fwd_data[k*XLEN +: XLEN];
      end
    end
    if (idx == '0) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  // NOTE: combinational blocks use blocking '=' and give every output a default first,
  // so no latch can be inferred; state is only ever updated with '<=' in always_ff.
  always_comb begin
    {hit1, val1} = resolve(rs1_o, rdata1);
    {hit2, val2} = resolve(rs2_o, rdata2);
    haz1   = uses_rs1 && (rs1_o != '0) && rf_busy[rs1_o] && !hit1;
    haz2   = uses_rs2 && (rs2_o != '0) && rf_busy[rs2_o] && !hit2;
    hazard = haz1 || haz2;
  end

  assign push  = in_valid && in_ready && !flush;
  assign issue = head_valid && !hazard && (!out_valid_q || out_ready) && !flush;
  assign pop   = issue;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= in_inst;
      pc_mem[wr_ptr_q]   <= in_pc;
      spec_mem[wr_ptr_q] <= in_spec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_rs1v_q  <= '0;
      out_rs2v_q  <= '0;
      out_spec_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (flush) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        if (issue) begin
          out_valid_q <= 1'b1;
          out_inst_q  <= head_inst;
          out_pc_q    <= pc_mem[rd_ptr_q];
          out_spec_q  <= spec_mem[rd_ptr_q];
          out_rs1v_q  <= val1;
          out_rs2v_q  <= val2;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
      if (head_valid && hazard && !flush && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign out_rs1v  = out_rs1v_q;
  assign out_rs2v  = out_rs2v_q;
  assign out_spec  = out_spec_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_idu_issue_q.sv
// Directed bench for ysyx_idu_issue_q: reset, fill, hazard/stall, forwarding, x0/use rules,
// flush, mid-run reset and a wrapping stream.
module tb_ysyx_idu_issue_q;

  localparam int XLEN = 32, RIDX_W = 4, DEPTH = 4, NFWD = 2, NREG = 16;

  localparam logic [31:0] ADDI_X0 = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI_X5 = 32'h0012_8093; // addi x1,x5,1
  localparam logic [31:0] ADD_156 = 32'h0062_80B3; // add  x1,x5,x6
  localparam logic [31:0] LUI_I   = 32'h1234_50B7; // lui  (rs1 field = 8)
  localparam logic [31:0] JAL_I   = 32'h000F_80EF; // jal  (rs1 field = 15)
  localparam logic [31:0] SW_I    = 32'h0060_2023; // sw   x6,0(x0)

  logic                   clk = 1'b0;
  logic                   rst = 1'b0, flush = 1'b0;
  logic                   in_valid = 1'b0, in_spec = 1'b0;
  logic                   in_ready;
  logic [31:0]            in_inst = '0;
  logic [XLEN-1:0]        in_pc = '0;
  logic [RIDX_W-1:0]      rs1_o, rs2_o;
  logic [XLEN-1:0]        rdata1, rdata2;
  logic [NREG-1:0]        rf_busy = '0;
  logic [NFWD-1:0]        fwd_valid = '0;
  logic [NFWD*RIDX_W-1:0] fwd_rd = '0;
  logic [NFWD*XLEN-1:0]   fwd_data = '0;
  logic                   out_valid, out_ready = 1'b0, out_spec;
  logic [31:0]            out_inst, stall_cnt;
  logic [XLEN-1:0]        out_pc, out_rs1v, out_rs2v;

  int vectors = 0;
  int errs    = 0;

  // Regfile stand-in: register r reads as 0x1000 + r.
  assign rdata1 = 32'h1000 + 32'(rs1_o);
  assign rdata2 = 32'h1000 + 32'(rs2_o);

  always #5 clk = ~clk;

  ysyx_idu_issue_q #(.XLEN(XLEN), .RIDX_W(RIDX_W), .DEPTH(DEPTH), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc), .in_spec(in_spec),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rdata1(rdata1), .rdata2(rdata2), .rf_busy(rf_busy),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .out_spec(out_spec), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; rf_busy = '0; fwd_valid = '0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    in_valid = 1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    vectors++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    vectors++; if ({out_inst, out_pc, out_rs1v, out_rs2v} !== '0) begin errs++; $display("FAIL reset_out_data got %h/%h/%h/%h exp 0", out_inst, out_pc, out_rs1v, out_rs2v); end
  endtask

  task automatic test_fill();
    do_reset();
    rf_busy[5] = 1'b1;
    for (int i = 0; i < 4; i++) push(ADDI_X5, 32'(4 * i));
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_full got in_ready=%0b exp 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fill_blocked got out_valid=%0b exp 0", out_valid); end
    push(ADDI_X5, 32'h10);
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_refused got in_ready=%0b exp 0", in_ready); end
    rf_busy = '0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errs++; $display("FAIL fill_first got v=%0b pc=%h exp 1/0", out_valid, out_pc); end
    vectors++; if (out_rs1v !== 32'h1005) begin errs++; $display("FAIL fill_rs1v got %h exp 1005", out_rs1v); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || in_ready !== 1'b1) begin errs++; $display("FAIL fill_hold got v=%0b pc=%h rdy=%0b exp 1/0/1", out_valid, out_pc, in_ready); end
    out_ready = 1;
    for (int i = 1; i < 4; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin errs++; $display("FAIL fill_drain%0d got v=%0b pc=%h exp 1/%h", i, out_valid, out_pc, 4 * i); end
    end
    tick();
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fill_fifth_dropped got out_valid=%0b pc=%h exp 0", out_valid, out_pc); end
  endtask

  task automatic test_hazard();
    do_reset();
    out_ready = 1;
    rf_busy[5] = 1'b1;
    push(ADD_156, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL hazard_hold%0d got out_valid=%0b exp 0", i, out_valid); end
    end
    vectors++; if (stall_cnt !== 32'd3) begin errs++; $display("FAIL hazard_stall got %0d exp 3", stall_cnt); end
    rf_busy = '0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_inst !== ADD_156 || out_pc !== 32'h100) begin errs++; $display("FAIL hazard_issue got v=%0b inst=%h pc=%h", out_valid, out_inst, out_pc); end
    vectors++; if (out_rs1v !== 32'h1005 || out_rs2v !== 32'h1006) begin errs++; $display("FAIL hazard_ops got %h/%h exp 1005/1006", out_rs1v, out_rs2v); end
    vectors++; if (stall_cnt !== 32'd3) begin errs++; $display("FAIL hazard_stall_hold got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    out_ready = 1;
    rf_busy[5] = 1'b1; rf_busy[6] = 1'b1;
    fwd_valid = 2'b11; fwd_rd = {4'd5, 4'd5}; fwd_data = {32'h22, 32'h11};
    push(ADD_156, 32'h200);
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fwd_rs2_hazard got out_valid=%0b exp 0", out_valid); end
    fwd_rd = {4'd5, 4'd6}; fwd_data = {32'h44, 32'h33};
    tick();
    vectors++; if (out_valid !== 1'b1 || out_rs1v !== 32'h44 || out_rs2v !== 32'h33) begin errs++; $display("FAIL fwd_split got v=%0b %h/%h exp 1/44/33", out_valid, out_rs1v, out_rs2v); end
    rf_busy = '0;
    fwd_rd = {4'd5, 4'd5}; fwd_data = {32'h22, 32'h11};
    push(ADD_156, 32'h204);
    tick();
    vectors++; if (out_pc !== 32'h204 || out_rs1v !== 32'h11 || out_rs2v !== 32'h1006) begin errs++; $display("FAIL fwd_priority got pc=%h %h/%h exp 204/11/1006", out_pc, out_rs1v, out_rs2v); end
    fwd_valid = '0;
  endtask

  task automatic test_x0_use();
    do_reset();
    out_ready = 1;
    rf_busy = '1;
    push(LUI_I, 32'h300);
    push(JAL_I, 32'h304);
    vectors++; if (out_valid !== 1'b1 || out_inst !== LUI_I) begin errs++; $display("FAIL use_lui got v=%0b inst=%h", out_valid, out_inst); end
    push(ADDI_X0, 32'h308);
    vectors++; if (out_valid !== 1'b1 || out_inst !== JAL_I) begin errs++; $display("FAIL use_jal got v=%0b inst=%h", out_valid, out_inst); end
    push(SW_I, 32'h30C);
    vectors++; if (out_valid !== 1'b1 || out_inst !== ADDI_X0 || out_rs1v !== 32'h0) begin errs++; $display("FAIL use_addi_x0 got v=%0b inst=%h rs1v=%h", out_valid, out_inst, out_rs1v); end
    tick();
    vectors++; if (out_valid !== 1'b0 || stall_cnt !== 32'd1) begin errs++; $display("FAIL use_store_rs2 got v=%0b stall=%0d exp 0/1", out_valid, stall_cnt); end
    rf_busy = '0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_inst !== SW_I || out_rs1v !== 32'h0 || out_rs2v !== 32'h1006) begin errs++; $display("FAIL use_store_issue got v=%0b inst=%h %h/%h", out_valid, out_inst, out_rs1v, out_rs2v); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) push(ADDI_X0, 32'(4 * i));
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errs++; $display("FAIL flush_pre got v=%0b pc=%h exp 1/0", out_valid, out_pc); end
    flush = 1; in_valid = 1; in_inst = ADDI_X0; in_pc = 32'h40;
    tick();
    flush = 0; in_valid = 0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_clear got v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    out_ready = 1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_empty got v=%0b pc=%h exp 0", out_valid, out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_busy[5] = 1'b1;
    push(ADDI_X5, 32'h500);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; rf_busy = '0;
    vectors++; if (stall_cnt !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL rst_mid got stall=%0d v=%0b rdy=%0b", stall_cnt, out_valid, in_ready); end
    out_ready = 1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_empty got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 10); in_inst = ADDI_X0; in_pc = 32'(4 * i);
      tick();
      vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready%0d got 0 exp 1", i); end
      if (i >= 1 && i <= 10) begin
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 1))) begin errs++; $display("FAIL stream_pc%0d got v=%0b pc=%h exp 1/%h", i, out_valid, out_pc, 4 * (i - 1)); end
      end else if (i == 11) begin
        vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_end got v=%0b exp 0", out_valid); end
      end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hazard();
    test_forward();
    test_x0_use();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
